// File: rtl/uart_pkg.sv
// Shared types and constants for the UART packet controller slice.
// Parser states, default frame marker and the command codes understood by the sequencer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        LEN_H   = 3'd2,
        LEN_L   = 3'd3,
        PAYLOAD = 3'd4,
        CSUM    = 3'd5
    } state_t;

    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

    localparam logic [7:0] CMD_LOAD_IMG = 8'h01;
    localparam logic [7:0] CMD_LOAD_WT  = 8'h02;
    localparam logic [7:0] CMD_START    = 8'h10;

endpackage

// File: rtl/uart_pkt_ctrl_if.sv
// Byte-strobe input, payload write port and packet status of the frame controller.
// master = controller side, slave = receiver/memory/sequencer side.
interface uart_pkt_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              rx_en;
    logic [7:0]        data_rx;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [7:0]        pkt_cmd;
    logic [15:0]       pkt_len;
    logic              pkt_done;
    logic              pkt_err;
    logic              busy;

    modport master (
        input  rx_en, data_rx,
        output wr_en, wr_addr, wr_data, pkt_cmd, pkt_len, pkt_done, pkt_err, busy
    );

    modport slave (
        output rx_en, data_rx,
        input  wr_en, wr_addr, wr_data, pkt_cmd, pkt_len, pkt_done, pkt_err, busy
    );
endinterface

// File: rtl/uart_pkt_timeout.sv
// Inter-byte watchdog: reloads on clr, counts down while en, pulses expire at zero.
// A clr in the expiring cycle suppresses the pulse so an arriving byte always wins.
module uart_pkt_timeout #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expire
);
    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign expire = en && !clr && (cnt_reg == '0);
endmodule

// File: rtl/uart_pkt_ctrl.sv
// Frame parser after the UART receiver: header, cmd, 16-bit length, payload, checksum.
// Payload bytes stream to the load memory; completion/abort reported as one-cycle pulses.
module uart_pkt_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DEF,
    parameter int          ADDR_W      = 12,
    parameter int          MAX_LEN     = 4096,
    parameter logic [31:0] TIMEOUT_CYC = 32'd4_000_000
) (
    input logic               clk,
    input logic               rstn,
    uart_pkt_ctrl_if.master   bus
);
    localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

    state_t            state_reg;
    logic [7:0]        csum_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [7:0]        wr_data_reg;
    logic [7:0]        pkt_cmd_reg;
    logic [15:0]       pkt_len_reg;
    logic              pkt_done_reg;
    logic              pkt_err_reg;
    logic              busy_reg;
    logic              tmo_expire;

    wire  [15:0]       full_len = {pkt_len_reg[15:8], bus.data_rx};

    uart_pkt_timeout #(.W(32)) u_timeout (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (bus.rx_en),
        .en       (state_reg != IDLE),
        .load_val (TIMEOUT_CYC - 32'd1),
        .expire   (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            csum_reg     <= '0;
            cnt_reg      <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            pkt_cmd_reg  <= '0;
            pkt_len_reg  <= '0;
            pkt_done_reg <= 1'b0;
            pkt_err_reg  <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            wr_en_reg    <= 1'b0;
            pkt_done_reg <= 1'b0;
            pkt_err_reg  <= 1'b0;
            if (bus.rx_en) begin
                case (state_reg)
                    IDLE: begin
                        if (bus.data_rx == HDR_BYTE) begin
                            state_reg <= CMD;
                            busy_reg  <= 1'b1;
                        end
                    end
                    CMD: begin
                        pkt_cmd_reg <= bus.data_rx;
                        csum_reg    <= bus.data_rx;
                        state_reg   <= LEN_H;
                    end
                    LEN_H: begin
                        pkt_len_reg[15:8] <= bus.data_rx;
                        csum_reg          <= csum_reg + bus.data_rx;
                        state_reg         <= LEN_L;
                    end
                    LEN_L: begin
                        pkt_len_reg[7:0] <= bus.data_rx;
                        csum_reg         <= csum_reg + bus.data_rx;
                        cnt_reg          <= '0;
                        if ({1'b0, full_len} > MAX_LEN_W) begin
                            pkt_err_reg <= 1'b1;
                            state_reg   <= IDLE;
                            busy_reg    <= 1'b0;
                        end else if (full_len == 16'd0) begin
                            state_reg <= CSUM;
                        end else begin
                            state_reg <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= cnt_reg;
                        wr_data_reg <= bus.data_rx;
                        csum_reg    <= csum_reg + bus.data_rx;
                        cnt_reg     <= cnt_reg + 1'b1;
                        if (16'(cnt_reg) == pkt_len_reg - 16'd1) begin
                            state_reg <= CSUM;
                        end
                    end
                    CSUM: begin
                        if (bus.data_rx == csum_reg) begin
                            pkt_done_reg <= 1'b1;
                        end else begin
                            pkt_err_reg <= 1'b1;
                        end
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end else if (tmo_expire) begin
                // Link went quiet mid-frame: abandon it so the next header can be taken.
                pkt_err_reg <= 1'b1;
                state_reg   <= IDLE;
                busy_reg    <= 1'b0;
            end
        end
    end

    assign bus.wr_en    = wr_en_reg;
    assign bus.wr_addr  = wr_addr_reg;
    assign bus.wr_data  = wr_data_reg;
    assign bus.pkt_cmd  = pkt_cmd_reg;
    assign bus.pkt_len  = pkt_len_reg;
    assign bus.pkt_done = pkt_done_reg;
    assign bus.pkt_err  = pkt_err_reg;
    assign bus.busy     = busy_reg;
endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Directed bench for uart_pkt_ctrl: good/bad checksum, junk, zero length, oversize,
// inter-byte timeout and mid-frame reset.
module tb_uart_pkt_ctrl;
    logic clk;
    logic rstn;
    int   total;
    int   passed;
    int   wr_count;

    uart_pkt_ctrl_if #(.ADDR_W(12)) bus ();

    uart_pkt_ctrl #(
        .HDR_BYTE    (8'hA5),
        .ADDR_W      (12),
        .MAX_LEN     (4096),
        .TIMEOUT_CYC (32'd100)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) wr_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Presents one byte strobe; on return the registered response to it is visible.
    task automatic send(input logic [7:0] b);
        bus.rx_en   = 1'b1;
        bus.data_rx = b;
        @(posedge clk);
        #1;
        bus.rx_en   = 1'b0;
        $display("t=%0t byte %02h -> wr_en=%0b addr=%0h data=%02h done=%0b err=%0b busy=%0b",
                 $time, b, bus.wr_en, bus.wr_addr, bus.wr_data, bus.pkt_done, bus.pkt_err, bus.busy);
    endtask

    task automatic check_wr(input string tag, input logic [11:0] addr, input logic [7:0] data);
        check({tag, "_wr_en"}, 32'(bus.wr_en), 32'd1);
        check({tag, "_addr"}, 32'(bus.wr_addr), 32'(addr));
        check({tag, "_data"}, 32'(bus.wr_data), 32'(data));
    endtask

    initial begin
        int wr_base;
        total       = 0;
        passed      = 0;
        wr_count    = 0;
        rstn        = 1'b0;
        bus.rx_en   = 1'b0;
        bus.data_rx = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.pkt_done), 32'd0);
        check("rst_err", 32'(bus.pkt_err), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_cmd", 32'(bus.pkt_cmd), 32'd0);
        check("rst_len", 32'(bus.pkt_len), 32'd0);
        rstn = 1'b1;

        // Good 3-byte frame: checksum 01+00+03+11+22+33 = 6A
        send(8'hA5);
        check("a_busy_hdr", 32'(bus.busy), 32'd1);
        send(8'h01);
        send(8'h00);
        send(8'h03);
        check("a_no_wr_hdr", 32'(bus.wr_en), 32'd0);
        send(8'h11); check_wr("a_w0", 12'd0, 8'h11);
        send(8'h22); check_wr("a_w1", 12'd1, 8'h22);
        send(8'h33); check_wr("a_w2", 12'd2, 8'h33);
        send(8'h6A);
        check("a_done", 32'(bus.pkt_done), 32'd1);
        check("a_err", 32'(bus.pkt_err), 32'd0);
        check("a_wr_off", 32'(bus.wr_en), 32'd0);
        check("a_cmd", 32'(bus.pkt_cmd), 32'h01);
        check("a_len", 32'(bus.pkt_len), 32'd3);
        check("a_busy_end", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        check("a_done_pulse", 32'(bus.pkt_done), 32'd0);

        // Same frame, bad checksum
        wr_base = wr_count;
        send(8'hA5); send(8'h01); send(8'h00); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33);
        check("b_busy_pre", 32'(bus.busy), 32'd1);
        send(8'h68);
        check("b_err", 32'(bus.pkt_err), 32'd1);
        check("b_done", 32'(bus.pkt_done), 32'd0);
        check("b_busy", 32'(bus.busy), 32'd0);
        check("b_writes", 32'(wr_count - wr_base), 32'd3);
        @(posedge clk); #1;
        check("b_err_pulse", 32'(bus.pkt_err), 32'd0);

        // Leading junk, then back-to-back zero-length frame
        wr_base = wr_count;
        send(8'h00); check("c_junk0_busy", 32'(bus.busy), 32'd0);
        send(8'hFF); check("c_junk1_busy", 32'(bus.busy), 32'd0);
        send(8'hA5); check("c_hdr_busy", 32'(bus.busy), 32'd1);
        send(8'h10); send(8'h00); send(8'h00);
        send(8'h10);
        check("c_done", 32'(bus.pkt_done), 32'd1);
        check("c_err", 32'(bus.pkt_err), 32'd0);
        check("c_cmd", 32'(bus.pkt_cmd), 32'h10);
        check("c_len", 32'(bus.pkt_len), 32'd0);
        check("c_writes", 32'(wr_count - wr_base), 32'd0);

        // Oversize length 0x1001
        wr_base = wr_count;
        send(8'hA5); send(8'h01); send(8'h10);
        check("d_err_early", 32'(bus.pkt_err), 32'd0);
        send(8'h01);
        check("d_err", 32'(bus.pkt_err), 32'd1);
        check("d_busy", 32'(bus.busy), 32'd0);
        check("d_len", 32'(bus.pkt_len), 32'h1001);
        send(8'h11);
        check("d_idle_no_wr", 32'(bus.wr_en), 32'd0);
        check("d_writes", 32'(wr_count - wr_base), 32'd0);

        // Timeout after first payload byte
        send(8'hA5); send(8'h01); send(8'h00); send(8'h02);
        send(8'h11); check_wr("e_w0", 12'd0, 8'h11);
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k < 100) begin
                check($sformatf("e_wait%0d_err", k), 32'(bus.pkt_err), 32'd0);
            end else begin
                check("e_tmo_err", 32'(bus.pkt_err), 32'd1);
                check("e_tmo_busy", 32'(bus.busy), 32'd0);
                check("e_tmo_done", 32'(bus.pkt_done), 32'd0);
            end
        end
        $display("t=%0t timeout window elapsed err=%0b", $time, bus.pkt_err);
        // Recovery frame: 02+00+01+7E = 81
        send(8'hA5); send(8'h02); send(8'h00); send(8'h01);
        send(8'h7E); check_wr("e_rec_w0", 12'd0, 8'h7E);
        send(8'h81);
        check("e_rec_done", 32'(bus.pkt_done), 32'd1);
        check("e_rec_cmd", 32'(bus.pkt_cmd), 32'h02);

        // Reset in the middle of a 4-byte payload
        send(8'hA5); send(8'h01); send(8'h00); send(8'h04);
        send(8'h11); send(8'h22);
        rstn = 1'b0;
        @(posedge clk); #1;
        $display("t=%0t reset pulse busy=%0b err=%0b", $time, bus.busy, bus.pkt_err);
        check("f_rst_busy", 32'(bus.busy), 32'd0);
        check("f_rst_err", 32'(bus.pkt_err), 32'd0);
        check("f_rst_wr", 32'(bus.wr_en), 32'd0);
        check("f_rst_cmd", 32'(bus.pkt_cmd), 32'd0);
        check("f_rst_len", 32'(bus.pkt_len), 32'd0);
        rstn = 1'b1;
        // Fresh frame: 01+00+01+55 = 57
        send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
        send(8'h55); check_wr("f_w0", 12'd0, 8'h55);
        send(8'h57);
        check("f_done", 32'(bus.pkt_done), 32'd1);
        check("f_err", 32'(bus.pkt_err), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
